mem_port_arbiter: RTL and testbench



---
 rtl/mem_port_if.sv | 36 +++
 rtl/mem_port_arbiter.sv | 74 +++++++
 tb/tb_mem_port_arbiter.sv | 297 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_port_if.sv
// mem_port_if: fetch, load/store and byte-wide RAM signals of mem_port_arbiter
// MEMPORT_IF_ABORT_EN adds if_flush for abandoning an in-flight fetch.
interface mem_port_if #(parameter int ADDR_W = 32);
  logic              if_req;
  logic [ADDR_W-1:0] if_addr;
  logic [31:0]       if_data;
  logic              if_done;
`ifdef MEMPORT_IF_ABORT_EN
  logic              if_flush;
`endif
  logic              mem_req;
  logic              mem_we;
  logic [1:0]        mem_len;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic [31:0]       mem_rdata;
  logic              mem_done;
  logic [ADDR_W-1:0] ram_addr;
  logic              ram_we;
  logic [7:0]        ram_dout;
  logic [7:0]        ram_din;
  modport master (
`ifdef MEMPORT_IF_ABORT_EN
    output if_flush,
`endif
    output if_req, if_addr, mem_req, mem_we, mem_len, mem_addr, mem_wdata, ram_din,
    input  if_data, if_done, mem_rdata, mem_done, ram_addr, ram_we, ram_dout
  );
  modport slave (
`ifdef MEMPORT_IF_ABORT_EN
    input  if_flush,
`endif
    input  if_req, if_addr, mem_req, mem_we, mem_len, mem_addr, mem_wdata, ram_din,
    output if_data, if_done, mem_rdata, mem_done, ram_addr, ram_we, ram_dout
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one byte-wide RAM port between fetch and load/store, little-endian
// Optional MEMPORT_IF_ABORT_EN: bus.if_flush abandons a fetch in its grant cycle or while reading.
module mem_port_arbiter #(
  parameter int ADDR_W = 32
) (
  input logic       clk,
  input logic       rst,
  mem_port_if.slave bus
);
  typedef enum logic [2:0] {IDLE, IF_RD, MEM_RD, MEM_WR, DONE} state_t;
  state_t            r_state, w_next;
  logic [ADDR_W-1:0] r_addr;
  logic [2:0]        r_len, r_cnt;
  logic [1:0]        w_sel;
  logic [31:0]       r_wdata, r_buf, r_if_data, r_mem_rdata, w_asm;
  logic              r_own_mem, w_flush, w_rd, w_rd_last, w_wr_last, w_grant;
`ifdef MEMPORT_IF_ABORT_EN
  assign w_flush = bus.if_flush;
`else
  assign w_flush = 1'b0;
`endif
  assign w_rd      = r_state == IF_RD || r_state == MEM_RD;
  // RAM data lags the address by one edge, so reads spend one extra cycle draining
  assign w_rd_last = r_cnt == r_len;
  assign w_wr_last = r_cnt + 3'd1 == r_len;
  assign w_grant   = r_state == IDLE && w_next != IDLE;
  assign w_sel     = r_cnt[1:0] - 2'd1;
  assign w_asm     = r_buf | ({24'd0, bus.ram_din} << {w_sel, 3'b000});
  always_ff @(posedge clk) r_state <= rst ? IDLE : w_next;
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    w_next = bus.mem_req ? (bus.mem_we ? MEM_WR : MEM_RD)
                      : (bus.if_req && !w_flush) ? IF_RD : IDLE;
      IF_RD:   w_next = w_flush ? IDLE : w_rd_last ? DONE : IF_RD;
      MEM_RD:  w_next = w_rd_last ? DONE : MEM_RD;
      MEM_WR:  w_next = w_wr_last ? DONE : MEM_WR;
      default: w_next = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      r_addr      <= '0;
      r_len       <= '0;
      r_cnt       <= '0;
      r_wdata     <= '0;
      r_buf       <= '0;
      r_if_data   <= '0;
      r_mem_rdata <= '0;
      r_own_mem   <= 1'b0;
    end else if (w_grant) begin
      r_addr    <= bus.mem_req ? bus.mem_addr : bus.if_addr;
      r_len     <= !bus.mem_req ? 3'd4 : bus.mem_len[1] ? 3'd4 : bus.mem_len[0] ? 3'd2 : 3'd1;
      r_cnt     <= '0;
      r_wdata   <= bus.mem_wdata;
      r_buf     <= '0;
      r_own_mem <= bus.mem_req;
    end else if (w_rd || r_state == MEM_WR) begin
      r_cnt   <= r_cnt + 3'd1;
      r_wdata <= r_wdata >> 8;
      if (r_cnt + 3'd1 < r_len) r_addr <= r_addr + ADDR_W'(1);
      if (w_rd && r_cnt != 3'd0) r_buf <= w_asm;
      if (w_rd && w_next == DONE && r_own_mem) r_mem_rdata <= w_asm;
      if (w_rd && w_next == DONE && !r_own_mem) r_if_data <= w_asm;
    end
  end
  assign bus.ram_addr  = r_addr;
  assign bus.ram_we    = r_state == MEM_WR;
  assign bus.ram_dout  = r_wdata[7:0];
  assign bus.if_data   = r_if_data;
  assign bus.mem_rdata = r_mem_rdata;
  assign bus.if_done   = r_state == DONE && !r_own_mem;
  assign bus.mem_done  = r_state == DONE && r_own_mem;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed and random traffic against a transaction-level schedule model
module tb_mem_port_arbiter;
  typedef struct {
    int          c;
    int          g;
    bit          we;
    bit          ca;
    logic [31:0] addr;
    logic [7:0]  dout;
    bit          ifd;
    bit          memd;
    logic [31:0] base;
    int          len;
  } ent_t;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int total = 0, bad = 0, cyc = 0;
  int m_gen = 0, m_rst_cyc = -1, m_free = 0, m_if_e0 = 0;
  bit m_started = 0, m_mem_busy = 0, m_if_busy = 0;
  logic [31:0] m_if = 0, m_mem = 0;
  logic [7:0] ram [logic [31:0]];
  logic [7:0] mdl [logic [31:0]];
  ent_t ex [64];
  always #5 clk = ~clk;
  mem_port_if #(.ADDR_W(32)) bus ();
  mem_port_arbiter #(.ADDR_W(32)) dut (.clk(clk), .rst(rst), .bus(bus));
  function automatic logic [7:0] init_byte(input logic [31:0] a);
    return (a[7:0] * 8'd3) ^ a[15:8] ^ a[31:24] ^ 8'hA5;
  endfunction
  function automatic logic [7:0] rd_ram(input logic [31:0] a);
    return ram.exists(a) ? ram[a] : init_byte(a);
  endfunction
  function automatic logic [7:0] rd_mdl(input logic [31:0] a);
    return mdl.exists(a) ? mdl[a] : init_byte(a);
  endfunction
  function automatic logic [31:0] asm_word(input logic [31:0] base, input int n);
    logic [31:0] v = 0;
    for (int k = 0; k < n; k++) v |= {24'h0, rd_mdl(base + 32'(k))} << (8 * k);
    return v;
  endfunction
  function automatic bit flush_in();
`ifdef MEMPORT_IF_ABORT_EN
    return bus.if_flush;
`else
    return 1'b0;
`endif
  endfunction
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s cyc=%0d got=%h want=%h", nm, cyc, act, exp);
    end
  endtask
  task automatic poke(input logic [31:0] a, input logic [7:0] v);
    ram[a] = v;
    mdl[a] = v;
  endtask
  // RAM: registered read of the address presented at the previous edge
  initial begin
    bus.ram_din = 8'h00;
    forever begin
      @(posedge clk);
      bus.ram_din <= rd_ram(bus.ram_addr);
      if (bus.ram_we) ram[bus.ram_addr] = bus.ram_dout;
    end
  end
  // Model: on each grant, lay out the per-cycle RAM traffic and the done cycle
  initial forever begin
    ent_t e;
    int n;
    @(posedge clk);
    cyc++;
    if (rst) begin
      m_gen++;
      m_rst_cyc = cyc;
      m_free = cyc + 1;
      m_mem_busy = 0;
      m_if_busy = 0;
      m_started = 1;
    end else begin
      if (flush_in() && m_if_busy && cyc - 1 >= m_if_e0 && cyc - 1 <= m_if_e0 + 4) begin
        m_gen++;
        m_if_busy = 0;
        m_free = cyc + 1;
      end
      if (m_started && cyc >= m_free && (bus.mem_req || (bus.if_req && !flush_in()))) begin
        if (bus.mem_req) begin
          n = bus.mem_len[1] ? 4 : bus.mem_len[0] ? 2 : 1;
          for (int k = 0; k < n; k++) begin
            e = '{default: 0};
            e.c = cyc + k; e.g = m_gen; e.ca = 1; e.addr = bus.mem_addr + 32'(k);
            e.we = bus.mem_we;
            e.dout = bus.mem_wdata[8*k +: 8];
            ex[e.c & 63] = e;
          end
          e = '{default: 0};
          e.c = cyc + n + (bus.mem_we ? 0 : 1); e.g = m_gen; e.memd = 1;
          e.base = bus.mem_addr; e.len = bus.mem_we ? 0 : n;
          ex[e.c & 63] = e;
          m_mem_busy = 1;
        end else begin
          for (int k = 0; k < 4; k++) begin
            e = '{default: 0};
            e.c = cyc + k; e.g = m_gen; e.ca = 1; e.addr = bus.if_addr + 32'(k);
            ex[e.c & 63] = e;
          end
          e = '{default: 0};
          e.c = cyc + 5; e.g = m_gen; e.ifd = 1; e.base = bus.if_addr; e.len = 4;
          ex[e.c & 63] = e;
          m_if_busy = 1;
          m_if_e0 = cyc;
        end
        m_free = e.c + 2;
      end
    end
  end
  // Compare every cycle, away from the active edge
  initial forever begin
    ent_t e;
    bit v;
    @(negedge clk);
    if (m_started) begin
      e = ex[cyc & 63];
      v = e.c == cyc && e.g == m_gen;
      chk("ram_we", 32'(bus.ram_we), 32'(v && e.we));
      if (v && e.ca) chk("ram_addr", bus.ram_addr, e.addr);
      if (v && e.we) begin
        chk("ram_dout", 32'(bus.ram_dout), 32'(e.dout));
        mdl[e.addr] = e.dout;
      end
      chk("if_done", 32'(bus.if_done), 32'(v && e.ifd));
      chk("mem_done", 32'(bus.mem_done), 32'(v && e.memd));
      if (cyc == m_rst_cyc) begin
        m_if = 0;
        m_mem = 0;
        chk("rst_ram_addr", bus.ram_addr, 32'h0);
        chk("rst_ram_dout", 32'(bus.ram_dout), 32'h0);
      end
      if (v && e.ifd) begin
        m_if = asm_word(e.base, 4);
        m_if_busy = 0;
      end
      if (v && e.memd) begin
        if (e.len > 0) m_mem = asm_word(e.base, e.len);
        m_mem_busy = 0;
      end
      chk("if_data", bus.if_data, m_if);
      chk("mem_rdata", bus.mem_rdata, m_mem);
    end
  end
  task automatic req_mem(input bit we, input logic [1:0] len, input logic [31:0] a, input logic [31:0] d);
    bus.mem_we = we;
    bus.mem_len = len;
    bus.mem_addr = a;
    bus.mem_wdata = d;
    bus.mem_req = 1;
  endtask
  task automatic wait_done(input bit is_mem, output int c, output int wc);
    c = -1;
    wc = 0;
    for (int i = 0; i < 40 && c < 0; i++) begin
      @(negedge clk);
      if (bus.ram_we) wc++;
      if (is_mem ? bus.mem_done : bus.if_done) c = cyc;
    end
    total++;
    if (c < 0) begin
      bad++;
      $display("FAIL %s_timeout cyc=%0d got=none want=pulse", is_mem ? "mem_done" : "if_done", cyc);
    end
    #1;
    if (is_mem) bus.mem_req = 0;
    else bus.if_req = 0;
  endtask
  function automatic logic [31:0] pick_addr();
    case ($urandom_range(0, 2))
      0: return $urandom;
      1: return 32'hFFFF_FFFC + $urandom_range(0, 3);
      default: return 32'h40 + $urandom_range(0, 15);
    endcase
  endfunction
  task automatic rand_mem();
    bus.mem_we = $urandom_range(0, 1) == 1;
    bus.mem_len = 2'($urandom_range(0, 3));
    bus.mem_addr = pick_addr();
    bus.mem_wdata = $urandom;
  endtask
  initial begin
    #1000000;
    $display("FAIL watchdog cyc=%0d got=running want=finished", cyc);
    $fatal(1);
  end
  initial begin
    int t, c, c2, wc, w, cnt;
    bus.if_req = 0; bus.if_addr = 0; bus.mem_req = 0; bus.mem_we = 0;
    bus.mem_len = 0; bus.mem_addr = 0; bus.mem_wdata = 0;
`ifdef MEMPORT_IF_ABORT_EN
    bus.if_flush = 0;
`endif
    repeat (3) @(posedge clk);
    @(negedge clk); #1 rst = 0;
    @(negedge clk);
    chk("reset_if_data", bus.if_data, 32'h0);
    chk("reset_mem_rdata", bus.mem_rdata, 32'h0);
    chk("reset_ram_we", 32'(bus.ram_we), 32'h0);
    #1;
    poke(32'h100, 8'h13); poke(32'h101, 8'h00); poke(32'h102, 8'h00); poke(32'h103, 8'h00);
    t = cyc; bus.if_addr = 32'h100; bus.if_req = 1;
    wait_done(0, c, wc);
    chk("fetch_latency", c - (t + 1), 5);
    chk("fetch_data", bus.if_data, 32'h0000_0013);
    chk("fetch_no_we", wc, 0);
    @(negedge clk); #1;
    t = cyc; req_mem(1, 2'b11, 32'h20, 32'hAABB_CCDD);
    wait_done(1, c, wc);
    chk("store_latency", c - (t + 1), 4);
    chk("store_we_cycles", wc, 4);
    chk("store_b0", 32'(rd_ram(32'h20)), 32'hDD);
    chk("store_b1", 32'(rd_ram(32'h21)), 32'hCC);
    chk("store_b2", 32'(rd_ram(32'h22)), 32'hBB);
    chk("store_b3", 32'(rd_ram(32'h23)), 32'hAA);
    @(negedge clk); #1;
    poke(32'h30, 8'h8F);
    t = cyc; bus.if_addr = 32'h200; bus.if_req = 1; req_mem(0, 2'b00, 32'h30, 32'h0);
    wait_done(1, c, wc);
    chk("both_mem_latency", c - (t + 1), 2);
    chk("both_mem_rdata", bus.mem_rdata, 32'h0000_008F);
    wait_done(0, c2, wc);
    chk("both_if_after_mem", c2 - c, 7);
    @(negedge clk); #1;
    poke(32'hFFFF_FFFF, 8'h12); poke(32'h0, 8'h34);
    req_mem(0, 2'b01, 32'hFFFF_FFFF, 32'h0);
    wait_done(1, c, wc);
    chk("wrap_half_load", bus.mem_rdata, 32'h0000_3412);
    @(negedge clk); #1;
    req_mem(1, 2'b10, 32'h80, 32'h1122_3344);
    w = 0;
    for (int i = 0; i < 40 && w < 2; i++) begin
      @(negedge clk);
      if (bus.ram_we) w++;
    end
    chk("abort_we_seen", w, 2);
    #1 rst = 1; bus.mem_req = 0;
    @(negedge clk);
    chk("abort_ram_we", 32'(bus.ram_we), 32'h0);
    chk("abort_mem_rdata", bus.mem_rdata, 32'h0);
    chk("abort_if_data", bus.if_data, 32'h0);
    #1 rst = 0;
    cnt = 0;
    repeat (8) begin
      @(negedge clk);
      if (bus.mem_done) cnt++;
    end
    chk("abort_no_done", cnt, 0);
    chk("abort_b2_unwritten", 32'(rd_ram(32'h82)), 32'(init_byte(32'h82)));
`ifdef MEMPORT_IF_ABORT_EN
    #1;
    bus.if_addr = 32'h300; bus.if_req = 1;
    @(negedge clk); #1;
    req_mem(0, 2'b00, 32'h30, 32'h0);
    @(negedge clk); #1;
    bus.if_flush = 1; bus.if_req = 0; t = cyc;
    @(negedge clk); #1;
    bus.if_flush = 0;
    wait_done(1, c, wc);
    chk("flush_mem_grant", c - t, 4);
    chk("flush_if_data", bus.if_data, 32'h0);
`endif
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk); #1;
      if (bus.mem_req) begin
        if (bus.mem_done) bus.mem_req = 0;
        else if (m_mem_busy) rand_mem();
      end else if ($urandom_range(0, 3) == 0) begin
        rand_mem();
        bus.mem_req = 1;
      end
      if (bus.if_req) begin
        if (bus.if_done) bus.if_req = 0;
        else if (m_if_busy) bus.if_addr = $urandom;
      end else if ($urandom_range(0, 2) == 0) begin
        bus.if_addr = pick_addr();
        bus.if_req = 1;
      end
      rst = $urandom_range(0, 299) == 0;
`ifdef MEMPORT_IF_ABORT_EN
      bus.if_flush = $urandom_range(0, 15) == 0;
`endif
    end
    @(negedge clk); #1;
    rst = 0; bus.mem_req = 0; bus.if_req = 0;
    repeat (10) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
